// File: rtl/mopshub_sdo_resp_tracker_if.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : mopshub_sdo_resp_tracker_if
// Description : Snoop/event bundle between the elink-side SDO traffic and the
//               SDO response tracker. The master side owns the snooped
//               downlink/uplink frames, the slave side owns the event outputs.
// Revision    : 1.0 - initial release
//==============================================================================
interface mopshub_sdo_resp_tracker_if;

  // Snooped frames: [75:68] bus_id, [67:57] cob_id, [56:0] payload
  logic        tra_valid;
  logic [75:0] data_tra_downlink;
  logic        rec_valid;
  logic [75:0] data_rec_uplink;

  // Tracker events and table status
  logic        match_pulse;
  logic        timeout_pulse;
  logic        err_pulse;
  logic [2:0]  err_code;
  logic [3:0]  evt_bus_id;
  logic [15:0] pending_mask;
  logic        all_idle;

  modport master (
    output tra_valid, data_tra_downlink, rec_valid, data_rec_uplink,
    input  match_pulse, timeout_pulse, err_pulse, err_code, evt_bus_id,
           pending_mask, all_idle
  );

  modport slave (
    input  tra_valid, data_tra_downlink, rec_valid, data_rec_uplink,
    output match_pulse, timeout_pulse, err_pulse, err_code, evt_bus_id,
           pending_mask, all_idle
  );

endinterface
`default_nettype wire

// File: rtl/mopshub_sdo_resp_tracker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : mopshub_sdo_resp_tracker
// Description : Tracks one outstanding SDO request per CAN bus, pairs uplink
//               responses with downlink requests, expires stale requests and
//               keeps per-bus match/timeout statistics.
// Revision    : 1.0 - initial release
//==============================================================================
module mopshub_sdo_resp_tracker #(
  parameter int N_BUS       = 16,     // table depth, at most 16 (4-bit bus ids)
  parameter int TIMEOUT_CYC = 40000,  // cycles until a pending request expires
  parameter int TMR_W       = 16      // timer width, TIMEOUT_CYC < 2**TMR_W
) (
  input  logic        clk_40_m,
  input  logic        rst,            // synchronous, active-low
  input  logic [4:0]  n_buses,
  input  logic        clr_stats,
  input  logic [3:0]  stat_sel,
  output logic [15:0] stat_match_cnt,
  output logic [15:0] stat_timeout_cnt,
  mopshub_sdo_resp_tracker_if.slave sdo
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int               c_IDX_W       = 4;
  localparam int               c_COB_W       = 11;
  localparam int               c_CNT_W       = 16;
  localparam int               c_TBL_MAX     = 16;
  localparam logic [7:0]       c_N_BUS_B     = 8'(N_BUS);
  localparam logic [10:0]      c_RESP_OFFSET = 11'h080;
  localparam logic [TMR_W-1:0] c_TMR_LOAD    = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] c_TMR_ONE     = TMR_W'(1);
  localparam logic [15:0]      c_CNT_ONE     = 16'h0001;
  localparam logic [15:0]      c_CNT_MAX     = 16'hFFFF;

  localparam logic [2:0] c_ERR_BAD_BUS = 3'b001;
  localparam logic [2:0] c_ERR_UNEXP   = 3'b010;
  localparam logic [2:0] c_ERR_COB     = 3'b011;
  localparam logic [2:0] c_ERR_OVERRUN = 3'b100;

  // ---------------------------------------------------------------------------
  // Frame field extraction
  // ---------------------------------------------------------------------------
  logic [7:0]         w_tra_bus;
  logic [7:0]         w_rec_bus;
  logic [10:0]        w_tra_cob;
  logic [10:0]        w_rec_cob;
  logic [c_IDX_W-1:0] w_tra_idx;
  logic [c_IDX_W-1:0] w_rec_idx;
  logic               w_tra_bad;
  logic               w_rec_bad;
  logic               w_unused_payload;

  assign w_tra_bus = sdo.data_tra_downlink[75:68];
  assign w_tra_cob = sdo.data_tra_downlink[67:57];
  assign w_rec_bus = sdo.data_rec_uplink[75:68];
  assign w_rec_cob = sdo.data_rec_uplink[67:57];
  assign w_tra_idx = w_tra_bus[c_IDX_W-1:0];
  assign w_rec_idx = w_rec_bus[c_IDX_W-1:0];

  // The payload is not inspected; only bus and COB-ID identify a transfer.
  assign w_unused_payload = ^{sdo.data_tra_downlink[56:0], sdo.data_rec_uplink[56:0]};

  // A bus id is invalid when it is not populated or lies outside the table.
  assign w_tra_bad = (w_tra_bus >= {3'b000, n_buses}) || (w_tra_bus >= c_N_BUS_B);
  assign w_rec_bad = (w_rec_bus >= {3'b000, n_buses}) || (w_rec_bus >= c_N_BUS_B);

  // ---------------------------------------------------------------------------
  // Table views (flattened from the per-bus entries below)
  // ---------------------------------------------------------------------------
  logic [N_BUS-1:0]             w_pending;
  logic [N_BUS-1:0]             w_expire;
  logic [N_BUS*c_COB_W-1:0]     w_cob_flat;
  logic [N_BUS*c_CNT_W-1:0]     w_mcnt_flat;
  logic [N_BUS*c_CNT_W-1:0]     w_tcnt_flat;
  logic [c_TBL_MAX*c_CNT_W-1:0] w_mcnt_pad;
  logic [c_TBL_MAX*c_CNT_W-1:0] w_tcnt_pad;
  logic [10:0]                  w_rec_req_cob;
  logic [10:0]                  w_rec_exp_cob;

  // Entries beyond N_BUS read as zero, which also covers stat_sel >= N_BUS.
  assign w_mcnt_pad = (c_TBL_MAX*c_CNT_W)'(w_mcnt_flat);
  assign w_tcnt_pad = (c_TBL_MAX*c_CNT_W)'(w_tcnt_flat);

  // A response to request COB 0x600+n carries COB 0x580+n.
  assign w_rec_req_cob = w_cob_flat[w_rec_idx*c_COB_W +: c_COB_W];
  assign w_rec_exp_cob = w_rec_req_cob - c_RESP_OFFSET;

  // ---------------------------------------------------------------------------
  // Request / response classification
  // ---------------------------------------------------------------------------
  logic       w_match;
  logic       w_rec_err;
  logic [2:0] w_rec_code;
  logic       w_tra_ok;
  logic       w_tra_err;
  logic [2:0] w_tra_code;

  // Classify this cycle's strobes; the response is judged against the old entry first.
  always_comb begin
    w_match    = 1'b0;
    w_rec_err  = 1'b0;
    w_rec_code = 3'b000;
    w_tra_ok   = 1'b0;
    w_tra_err  = 1'b0;
    w_tra_code = 3'b000;

    if (sdo.rec_valid) begin
      if (w_rec_bad) begin
        w_rec_err  = 1'b1;
        w_rec_code = c_ERR_BAD_BUS;
      end else if (!w_pending[w_rec_idx]) begin
        w_rec_err  = 1'b1;
        w_rec_code = c_ERR_UNEXP;
      end else if (w_rec_cob == w_rec_exp_cob) begin
        w_match    = 1'b1;
      end else begin
        w_rec_err  = 1'b1;
        w_rec_code = c_ERR_COB;
      end
    end

    if (sdo.tra_valid) begin
      if (w_tra_bad) begin
        w_tra_err  = 1'b1;
        w_tra_code = c_ERR_BAD_BUS;
      end else begin
        w_tra_ok = 1'b1;
        // A request landing on an entry just freed by a matching response is not an overrun.
        if (w_pending[w_tra_idx] && !(w_match && (w_rec_idx == w_tra_idx))) begin
          w_tra_err  = 1'b1;
          w_tra_code = c_ERR_OVERRUN;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-bus table entries and statistics
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_BUS; i++) begin : g_bus
    logic             r_pend;
    logic [10:0]      r_cob;
    logic [TMR_W-1:0] r_timer;
    logic [15:0]      r_match_cnt;
    logic [15:0]      r_tmo_cnt;
    logic             w_arm;
    logic             w_hit;
    logic             w_exp;

    assign w_arm = w_tra_ok && (w_tra_idx == c_IDX_W'(i));
    assign w_hit = w_match  && (w_rec_idx == c_IDX_W'(i));
    // A match or a fresh request on the final timer cycle cancels the expiry.
    assign w_exp = r_pend && (r_timer == c_TMR_ONE) && !w_hit && !w_arm;

    assign w_pending[i]                       = r_pend;
    assign w_expire[i]                        = w_exp;
    assign w_cob_flat[i*c_COB_W +: c_COB_W]   = r_cob;
    assign w_mcnt_flat[i*c_CNT_W +: c_CNT_W]  = r_match_cnt;
    assign w_tcnt_flat[i*c_CNT_W +: c_CNT_W]  = r_tmo_cnt;

    // Entry lifecycle: arm on request, free on match or expiry, count down while pending.
    always_ff @(posedge clk_40_m) begin
      if (!rst) begin
        r_pend  <= 1'b0;
        r_cob   <= '0;
        r_timer <= '0;
      end else if (w_arm) begin
        r_pend  <= 1'b1;
        r_cob   <= w_tra_cob;
        r_timer <= c_TMR_LOAD;
      end else if (w_hit || w_exp) begin
        r_pend  <= 1'b0;
      end else if (r_pend) begin
        r_timer <= r_timer - c_TMR_ONE;
      end
    end

    // Saturating statistics; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_40_m) begin
      if (!rst || clr_stats) begin
        r_match_cnt <= '0;
        r_tmo_cnt   <= '0;
      end else begin
        if (w_hit && (r_match_cnt != c_CNT_MAX)) begin
          r_match_cnt <= r_match_cnt + c_CNT_ONE;
        end
        if (w_exp && (r_tmo_cnt != c_CNT_MAX)) begin
          r_tmo_cnt <= r_tmo_cnt + c_CNT_ONE;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Timeout reporting
  // ---------------------------------------------------------------------------
  logic               w_tmo_any;
  logic [c_IDX_W-1:0] w_tmo_bus;

  // Lowest-index expiring bus is the one reported when several expire together.
  always_comb begin
    w_tmo_any = |w_expire;
    w_tmo_bus = '0;
    for (int j = N_BUS - 1; j >= 0; j--) begin
      if (w_expire[j]) begin
        w_tmo_bus = c_IDX_W'(j);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered event outputs
  // ---------------------------------------------------------------------------
  logic       r_match_pulse;
  logic       r_tmo_pulse;
  logic       r_err_pulse;
  logic [2:0] r_err_code;
  logic [3:0] r_evt_bus_id;

  // One-cycle pulses plus sticky error code and event bus (match > error > timeout).
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_match_pulse <= 1'b0;
      r_tmo_pulse   <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_err_code    <= 3'b000;
      r_evt_bus_id  <= 4'h0;
    end else begin
      r_match_pulse <= w_match;
      r_tmo_pulse   <= w_tmo_any;
      r_err_pulse   <= w_rec_err || w_tra_err;

      if (w_rec_err) begin
        r_err_code <= w_rec_code;
      end else if (w_tra_err) begin
        r_err_code <= w_tra_code;
      end

      // An out-of-range bus id is reported by its low four bits.
      if (w_match) begin
        r_evt_bus_id <= w_rec_idx;
      end else if (w_rec_err) begin
        r_evt_bus_id <= w_rec_bus[3:0];
      end else if (w_tra_err) begin
        r_evt_bus_id <= w_tra_bus[3:0];
      end else if (w_tmo_any) begin
        r_evt_bus_id <= w_tmo_bus;
      end
    end
  end

  assign sdo.match_pulse   = r_match_pulse;
  assign sdo.timeout_pulse = r_tmo_pulse;
  assign sdo.err_pulse     = r_err_pulse;
  assign sdo.err_code      = r_err_code;
  assign sdo.evt_bus_id    = r_evt_bus_id;
  assign sdo.pending_mask  = 16'(w_pending);
  assign sdo.all_idle      = ~|w_pending;

  // ---------------------------------------------------------------------------
  // Statistics readout
  // ---------------------------------------------------------------------------
  logic [15:0] r_stat_match;
  logic [15:0] r_stat_tmo;

  // Registered readout mux, one cycle behind stat_sel.
  always_ff @(posedge clk_40_m) begin
    if (!rst) begin
      r_stat_match <= '0;
      r_stat_tmo   <= '0;
    end else begin
      r_stat_match <= w_mcnt_pad[stat_sel*c_CNT_W +: c_CNT_W];
      r_stat_tmo   <= w_tcnt_pad[stat_sel*c_CNT_W +: c_CNT_W];
    end
  end

  assign stat_match_cnt   = r_stat_match;
  assign stat_timeout_cnt = r_stat_tmo;

endmodule
`default_nettype wire

// File: tb/tb_mopshub_sdo_resp_tracker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module      : tb_mopshub_sdo_resp_tracker
// Description : Self-checking bench for the SDO response tracker: directed
//               scenarios plus randomized traffic against a deadline-based
//               reference model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_mopshub_sdo_resp_tracker;

  localparam int N = 16;
  localparam int T = 40000;

  logic        clk_40_m = 1'b0;
  logic        rst      = 1'b0;
  logic [4:0]  n_buses;
  logic        clr_stats;
  logic [3:0]  stat_sel;
  logic [15:0] stat_match_cnt;
  logic [15:0] stat_timeout_cnt;

  mopshub_sdo_resp_tracker_if sif ();

  mopshub_sdo_resp_tracker #(
    .N_BUS       (N),
    .TIMEOUT_CYC (T),
    .TMR_W       (16)
  ) dut (
    .clk_40_m         (clk_40_m),
    .rst              (rst),
    .n_buses          (n_buses),
    .clr_stats        (clr_stats),
    .stat_sel         (stat_sel),
    .stat_match_cnt   (stat_match_cnt),
    .stat_timeout_cnt (stat_timeout_cnt),
    .sdo              (sif)
  );

  always #12.5 clk_40_m = ~clk_40_m;

  int n_checks = 0;
  int n_errors = 0;
  int tick_n   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: each pending request carries an absolute expiry edge.
  // ---------------------------------------------------------------------------
  bit          m_pend     [N];
  logic [10:0] m_cob      [N];
  longint      m_deadline [N];
  int unsigned m_mcnt     [N];
  int unsigned m_tcnt     [N];
  longint      edge_n = 0;

  logic        e_match, e_tmo, e_err;
  logic [2:0]  e_code;
  logic [3:0]  e_evt;
  logic [15:0] e_stat_m, e_stat_t;

  always @(posedge clk_40_m) begin : ref_model
    int          rb, tb_i, lowest;
    logic [10:0] rcob, tcob;
    bit          match, rec_err, tra_err, arm;
    bit          expd [N];
    logic [2:0]  code_r, code_t;

    edge_n++;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_cob[i] = '0; m_deadline[i] = 0; m_mcnt[i] = 0; m_tcnt[i] = 0;
      end
      e_match = 0; e_tmo = 0; e_err = 0; e_code = 0; e_evt = 0; e_stat_m = 0; e_stat_t = 0;
    end else begin
      e_stat_m = 16'(m_mcnt[stat_sel]);
      e_stat_t = 16'(m_tcnt[stat_sel]);

      rb   = int'(sif.data_rec_uplink[75:68]);
      rcob = sif.data_rec_uplink[67:57];
      tb_i = int'(sif.data_tra_downlink[75:68]);
      tcob = sif.data_tra_downlink[67:57];
      match = 0; rec_err = 0; tra_err = 0; arm = 0; code_r = 0; code_t = 0;

      if (sif.rec_valid) begin
        if (rb >= int'(n_buses) || rb >= N)        begin rec_err = 1; code_r = 3'd1; end
        else if (!m_pend[rb])                       begin rec_err = 1; code_r = 3'd2; end
        else if (rcob == 11'(m_cob[rb] - 11'h080))  match = 1;
        else                                        begin rec_err = 1; code_r = 3'd3; end
      end
      if (sif.tra_valid) begin
        if (tb_i >= int'(n_buses) || tb_i >= N) begin tra_err = 1; code_t = 3'd1; end
        else begin
          arm = 1;
          if (m_pend[tb_i] && !(match && rb == tb_i)) begin tra_err = 1; code_t = 3'd4; end
        end
      end

      lowest = -1;
      for (int i = 0; i < N; i++) begin
        expd[i] = m_pend[i] && (m_deadline[i] == edge_n) &&
                  !(match && rb == i) && !(arm && tb_i == i);
        if (expd[i] && lowest < 0) lowest = i;
      end

      if (match) begin
        m_pend[rb] = 0;
        if (m_mcnt[rb] < 65535) m_mcnt[rb]++;
      end
      for (int i = 0; i < N; i++) begin
        if (expd[i]) begin
          m_pend[i] = 0;
          if (m_tcnt[i] < 65535) m_tcnt[i]++;
        end
      end
      if (arm) begin
        m_pend[tb_i] = 1; m_cob[tb_i] = tcob; m_deadline[tb_i] = edge_n + T;
      end
      if (clr_stats) begin
        for (int i = 0; i < N; i++) begin m_mcnt[i] = 0; m_tcnt[i] = 0; end
      end

      e_match = match;
      e_tmo   = (lowest >= 0);
      e_err   = rec_err || tra_err;
      if (rec_err)      e_code = code_r;
      else if (tra_err) e_code = code_t;
      if (match)            e_evt = 4'(rb);
      else if (rec_err)     e_evt = 4'(rb);
      else if (tra_err)     e_evt = 4'(tb_i);
      else if (lowest >= 0) e_evt = 4'(lowest);
    end
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (tick %0d)", tag, got, exp, tick_n);
      if (n_errors >= 40) finish_run();
    end
  endtask

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int i = 0; i < N; i++) m[i] = m_pend[i];
    return m;
  endfunction

  // Advance one clock and compare every output with the model.
  task automatic tick();
    @(negedge clk_40_m);
    tick_n++;
    chk("match_pulse",   32'(sif.match_pulse),   32'(e_match));
    chk("timeout_pulse", 32'(sif.timeout_pulse), 32'(e_tmo));
    chk("err_pulse",     32'(sif.err_pulse),     32'(e_err));
    chk("err_code",      32'(sif.err_code),      32'(e_code));
    chk("evt_bus_id",    32'(sif.evt_bus_id),    32'(e_evt));
    chk("pending_mask",  32'(sif.pending_mask),  32'(model_mask()));
    chk("all_idle",      32'(sif.all_idle),      32'(model_mask() == 16'h0));
    chk("stat_match",    32'(stat_match_cnt),    32'(e_stat_m));
    chk("stat_timeout",  32'(stat_timeout_cnt),  32'(e_stat_t));
  endtask

  task automatic cyc(input bit tv, input logic [7:0] tbus, input logic [10:0] tcob,
                     input bit rv, input logic [7:0] rbus, input logic [10:0] rcob,
                     input bit clr);
    sif.tra_valid         = tv;
    sif.data_tra_downlink = {tbus, tcob, 57'({$urandom(), $urandom()})};
    sif.rec_valid         = rv;
    sif.data_rec_uplink   = {rbus, rcob, 57'({$urandom(), $urandom()})};
    clr_stats             = clr;
    tick();
    sif.tra_valid = 1'b0;
    sif.rec_valid = 1'b0;
    clr_stats     = 1'b0;
  endtask

  task automatic req(input logic [7:0] bus, input logic [10:0] cob);
    cyc(1'b1, bus, cob, 1'b0, 8'h00, 11'h000, 1'b0);
  endtask

  task automatic resp(input logic [7:0] bus, input logic [10:0] cob);
    cyc(1'b0, 8'h00, 11'h000, 1'b1, bus, cob, 1'b0);
  endtask

  // Hard bound on simulated time.
  initial begin
    #3_000_000;
    $display("FAIL watchdog got tick %0d expected completion", tick_n);
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int k5, k6, k4, t5_seen, t4_seen, n_tmo;
    bit match_at_expiry;

    n_buses = 5'd16; clr_stats = 0; stat_sel = 0;
    sif.tra_valid = 0; sif.rec_valid = 0;
    sif.data_tra_downlink = '0; sif.data_rec_uplink = '0;
    rst = 1'b0;
    tick(); tick();
    chk("rst_all_idle", 32'(sif.all_idle), 32'd1);
    chk("rst_mask",     32'(sif.pending_mask), 32'd0);
    chk("rst_err_code", 32'(sif.err_code), 32'd0);
    rst = 1'b1;
    tick();

    // Basic request / response pairing
    req(8'd3, 11'h603);
    chk("t1_mask_set", 32'(sif.pending_mask[3]), 32'd1);
    repeat (100) tick();
    resp(8'd3, 11'h583);
    chk("t1_match",    32'(sif.match_pulse), 32'd1);
    chk("t1_mask_clr", 32'(sif.pending_mask[3]), 32'd0);
    chk("t1_evt",      32'(sif.evt_bus_id), 32'd3);
    tick();
    chk("t1_pulse_1cyc", 32'(sif.match_pulse), 32'd0);
    stat_sel = 4'd3;
    tick();
    chk("t1_stat_match", 32'(stat_match_cnt), 32'd1);

    // Bad bus and unexpected response
    n_buses = 5'd3;
    req(8'd7, 11'h607);
    chk("t3_bad_bus_code", 32'(sif.err_code), 32'd1);
    chk("t3_bad_bus_mask", 32'(sif.pending_mask), 32'd0);
    resp(8'd1, 11'h581);
    chk("t3_unexp_code", 32'(sif.err_code), 32'd2);
    n_buses = 5'd16;

    // COB mismatch keeps the entry pending
    req(8'd2, 11'h602);
    resp(8'd2, 11'h584);
    chk("t4_cob_code", 32'(sif.err_code), 32'd3);
    chk("t4_cob_mask", 32'(sif.pending_mask[2]), 32'd1);
    resp(8'd2, 11'h582);
    chk("t4_match", 32'(sif.match_pulse), 32'd1);

    // clr_stats together with a match increment
    req(8'd3, 11'h603);
    cyc(1'b0, 8'h00, 11'h000, 1'b1, 8'd3, 11'h583, 1'b1);
    chk("t6_clr_match", 32'(sif.match_pulse), 32'd1);
    tick();
    chk("t6_clr_wins", 32'(stat_match_cnt), 32'd0);

    // Same-bus response and request: match, then re-arm without overrun
    req(8'd6, 11'h606);
    cyc(1'b1, 8'd6, 11'h616, 1'b1, 8'd6, 11'h586, 1'b0);
    chk("same_bus_match", 32'(sif.match_pulse), 32'd1);
    chk("same_bus_no_err", 32'(sif.err_pulse), 32'd0);
    chk("same_bus_rearm", 32'(sif.pending_mask[6]), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 2000; c++) begin
      bit tv, rv, clr;
      int tb_b, rb_b;
      logic [10:0] tc, rc;
      if ($urandom_range(0, 49) == 0) n_buses = 5'($urandom_range(1, 20));
      stat_sel = 4'($urandom());
      tv   = ($urandom_range(0, 2) == 0);
      rv   = ($urandom_range(0, 2) == 0);
      tb_b = $urandom_range(0, 17);
      rb_b = ($urandom_range(0, 3) == 0) ? tb_b : $urandom_range(0, 17);
      tc   = ($urandom_range(0, 7) != 0) ? 11'(11'h600 + tb_b) : 11'($urandom());
      rc   = (rb_b < N && $urandom_range(0, 4) != 0) ? 11'(m_cob[rb_b] - 11'h080)
                                                     : 11'($urandom());
      clr  = ($urandom_range(0, 99) == 0);
      cyc(tv, 8'(tb_b), tc, rv, 8'(rb_b), rc, clr);
    end
    n_buses = 5'd16;

    // Reset with a request outstanding
    req(8'd9, 11'h609);
    rst = 1'b0;
    tick();
    chk("t6_rst_mask", 32'(sif.pending_mask), 32'd0);
    chk("t6_rst_idle", 32'(sif.all_idle), 32'd1);
    rst = 1'b1;
    tick();

    // Timeouts, overrun restart and a match on the expiry cycle
    req(8'd5, 11'h605); k5 = tick_n;
    req(8'd6, 11'h606); k6 = tick_n;
    req(8'd4, 11'h604);
    repeat (9) tick();
    req(8'd4, 11'h614); k4 = tick_n;
    chk("t5_overrun_code", 32'(sif.err_code), 32'd4);
    chk("t5_overrun_evt",  32'(sif.evt_bus_id), 32'd4);

    t5_seen = -1; t4_seen = -1; n_tmo = 0; match_at_expiry = 0;
    while (tick_n < k4 + T + 5) begin
      if (tick_n + 1 == k6 + T) begin
        resp(8'd6, 11'h586);
        match_at_expiry = sif.match_pulse;
      end else begin
        tick();
      end
      if (sif.timeout_pulse) begin
        n_tmo++;
        if (sif.evt_bus_id == 4'd5) t5_seen = tick_n;
        if (sif.evt_bus_id == 4'd4) t4_seen = tick_n;
      end
    end
    chk("t2_timeout_time", 32'(t5_seen), 32'(k5 + T));
    chk("t5_timeout_time", 32'(t4_seen), 32'(k4 + T));
    chk("t6_timeout_count", 32'(n_tmo), 32'd2);
    chk("t6_expiry_match", 32'(match_at_expiry), 32'd1);
    chk("t2_all_idle", 32'(sif.all_idle), 32'd1);

    stat_sel = 4'd5; tick();
    chk("t2_stat_timeout", 32'(stat_timeout_cnt), 32'd1);
    stat_sel = 4'd4; tick();
    chk("t5_stat_timeout", 32'(stat_timeout_cnt), 32'd1);
    stat_sel = 4'd6; tick();
    chk("t6_stat_timeout", 32'(stat_timeout_cnt), 32'd0);
    chk("t6_stat_match",   32'(stat_match_cnt), 32'd1);

    finish_run();
  end

endmodule
`default_nettype wire
